// File: rtl/rv32.sv
//------------------------------------------------------------------------------
// rv32 : shared XLEN, mtimer word map / ctrl field positions, byte-merge helper
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rv32;

  localparam int XLEN = 32;

  localparam int MTIMER_MTIME_LO  = 0;
  localparam int MTIMER_MTIME_HI  = 1;
  localparam int MTIMER_CTRL      = 2;
  localparam int MTIMER_PENDING   = 3;
  localparam int MTIMER_CMP_BASE  = 4;

  localparam int MTIMER_CTRL_EN_BIT  = 0;
  localparam int MTIMER_CTRL_DIV_LSB = 8;

  function automatic logic [XLEN-1:0] merge_bytes(
    input logic [XLEN-1:0]   i_old,
    input logic [XLEN-1:0]   i_new,
    input logic [XLEN/8-1:0] i_strb
  );
    logic [XLEN-1:0] w_res;
    w_res = i_old;
    for (int b = 0; b < XLEN/8; b++) begin
      if (i_strb[b]) w_res[8*b +: 8] = i_new[8*b +: 8];
    end
    return w_res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mtimer_prescaler.sv
//------------------------------------------------------------------------------
// mtimer_prescaler : one-cycle tick every DIV+1 enabled cycles (MTIMER_PRESCALE_EN)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifdef MTIMER_PRESCALE_EN
module mtimer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic [PRESCALE_W-1:0] i_div,
  input  logic                  i_clr,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] r_cnt;
  logic                  w_hit;

  // >= keeps the divider self-recovering even if DIV ever drops below the count
  assign w_hit  = (r_cnt >= i_div);
  assign o_tick = i_en && w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_hit ? '0 : r_cnt + PRESCALE_W'(1);
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/mtimer_n.sv
//------------------------------------------------------------------------------
// mtimer_n : 64-bit mtime with NUM_CMP mtimecmp channels; DIV field under MTIMER_PRESCALE_EN
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mtimer_n
  import rv32::*;
#(
  parameter  int NUM_CMP    = 1,
  parameter  int PRESCALE_W = 8,
  localparam int ADDR_W     = $clog2(4 + 2*NUM_CMP)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_rd_en,
  input  logic                i_wr_en,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [XLEN-1:0]     i_wr_data,
  input  logic [XLEN/8-1:0]   i_wr_strobe,
  output logic [XLEN-1:0]     o_rd_data,
  output logic [63:0]         o_time_rd_data,
  output logic [NUM_CMP-1:0]  o_interrupt
);

  logic [63:0]                r_mtime;
  logic [NUM_CMP-1:0][63:0]   r_cmp;
  logic                       r_en;
  logic [XLEN-1:0]            r_rd_data;
  logic [31:0]                r_hi_shadow;
  logic                       r_shadow_vld;

  logic                       w_wr_lo;
  logic                       w_wr_hi;
  logic                       w_wr_ctrl;
  logic                       w_rd_lo;
  logic                       w_tick;
  logic                       w_en_nxt;
  logic [XLEN-1:0]            w_ctrl;
  logic [XLEN-1:0]            w_rd_mux;
  logic [NUM_CMP-1:0]         w_irq;

  assign w_wr_lo   = i_wr_en && (i_addr == ADDR_W'(MTIMER_MTIME_LO));
  assign w_wr_hi   = i_wr_en && (i_addr == ADDR_W'(MTIMER_MTIME_HI));
  assign w_wr_ctrl = i_wr_en && (i_addr == ADDR_W'(MTIMER_CTRL));
  assign w_rd_lo   = i_rd_en && (i_addr == ADDR_W'(MTIMER_MTIME_LO));
  assign w_en_nxt  = i_wr_strobe[MTIMER_CTRL_EN_BIT/8] ? i_wr_data[MTIMER_CTRL_EN_BIT] : r_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en <= 1'b1;
    end else if (w_wr_ctrl) begin
      r_en <= w_en_nxt;
    end
  end

`ifdef MTIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] r_div;
  logic [PRESCALE_W-1:0] w_div_nxt;
  logic                  w_psc_clr;

  assign w_psc_clr = w_wr_lo || w_wr_hi || w_wr_ctrl;

  always_comb begin
    w_div_nxt = r_div;
    for (int i = 0; i < PRESCALE_W; i++) begin
      if (i_wr_strobe[(MTIMER_CTRL_DIV_LSB + i)/8]) w_div_nxt[i] = i_wr_data[MTIMER_CTRL_DIV_LSB + i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_wr_ctrl) begin
      r_div <= w_div_nxt;
    end
  end

  mtimer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (r_en),
    .i_div  (r_div),
    .i_clr  (w_psc_clr),
    .o_tick (w_tick)
  );
`else
  assign w_tick = r_en;
`endif

  always_comb begin
    w_ctrl = '0;
    w_ctrl[MTIMER_CTRL_EN_BIT] = r_en;
`ifdef MTIMER_PRESCALE_EN
    w_ctrl[MTIMER_CTRL_DIV_LSB +: PRESCALE_W] = r_div;
`else
    w_ctrl[MTIMER_CTRL_DIV_LSB +: PRESCALE_W] = '0;
`endif
  end

  // A write to either half holds the whole counter for that cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtime <= '0;
    end else if (w_wr_lo) begin
      r_mtime[31:0] <= merge_bytes(r_mtime[31:0], i_wr_data, i_wr_strobe);
    end else if (w_wr_hi) begin
      r_mtime[63:32] <= merge_bytes(r_mtime[63:32], i_wr_data, i_wr_strobe);
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp <= '1;
    end else if (i_wr_en) begin
      for (int k = 0; k < NUM_CMP; k++) begin
        if (i_addr == ADDR_W'(MTIMER_CMP_BASE + 2*k))
          r_cmp[k][31:0] <= merge_bytes(r_cmp[k][31:0], i_wr_data, i_wr_strobe);
        if (i_addr == ADDR_W'(MTIMER_CMP_BASE + 2*k + 1))
          r_cmp[k][63:32] <= merge_bytes(r_cmp[k][63:32], i_wr_data, i_wr_strobe);
      end
    end
  end

  for (genvar k = 0; k < NUM_CMP; k++) begin : g_cmp
    assign w_irq[k] = (r_mtime >= r_cmp[k]);
  end

  always_comb begin
    w_rd_mux = '0;
    if (i_addr == ADDR_W'(MTIMER_MTIME_LO)) begin
      w_rd_mux = r_mtime[31:0];
    end else if (i_addr == ADDR_W'(MTIMER_MTIME_HI)) begin
      w_rd_mux = r_shadow_vld ? r_hi_shadow : r_mtime[63:32];
    end else if (i_addr == ADDR_W'(MTIMER_CTRL)) begin
      w_rd_mux = w_ctrl;
    end else if (i_addr == ADDR_W'(MTIMER_PENDING)) begin
      w_rd_mux = XLEN'(w_irq);
    end else begin
      for (int k = 0; k < NUM_CMP; k++) begin
        if (i_addr == ADDR_W'(MTIMER_CMP_BASE + 2*k))     w_rd_mux = r_cmp[k][31:0];
        if (i_addr == ADDR_W'(MTIMER_CMP_BASE + 2*k + 1)) w_rd_mux = r_cmp[k][63:32];
      end
    end
  end

  // Shadow survives only until the next bus access of any kind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data    <= '0;
      r_hi_shadow  <= '0;
      r_shadow_vld <= 1'b0;
    end else begin
      if (i_rd_en) r_rd_data <= w_rd_mux;
      if (i_rd_en || i_wr_en) begin
        r_shadow_vld <= w_rd_lo;
        if (w_rd_lo) r_hi_shadow <= r_mtime[63:32];
      end
    end
  end

  assign o_rd_data      = r_rd_data;
  assign o_time_rd_data = r_mtime;
  assign o_interrupt    = w_irq;

endmodule

`default_nettype wire

// File: tb/tb_mtimer_n.sv
//------------------------------------------------------------------------------
// tb_mtimer_n : directed + random bus traffic against a behavioural timer model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mtimer_n;

  localparam int NC = 3;
  localparam int PW = 8;
  localparam int AW = $clog2(4 + 2*NC);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_en = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wdata = '0;
  logic [3:0]    strb = '0;
  logic [31:0]   rdata;
  logic [63:0]   tdata;
  logic [NC-1:0] irq;

  mtimer_n #(.NUM_CMP(NC), .PRESCALE_W(PW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_rd_en        (rd_en),
    .i_wr_en        (wr_en),
    .i_addr         (addr),
    .i_wr_data      (wdata),
    .i_wr_strobe    (strb),
    .o_rd_data      (rdata),
    .o_time_rd_data (tdata),
    .o_interrupt    (irq)
  );

  always #5 clk = ~clk;

  logic [63:0] m_time;
  logic [63:0] m_cmp [NC];
  logic        m_en;
  int          m_div;
  int          m_phase;
  logic        m_sv;
  logic [31:0] m_sh;
  logic [31:0] m_rd;
  int          total = 0;
  int          bad = 0;
  bit          chk_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] v;
    v = o;
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = n[8*b +: 8];
    return v;
  endfunction

  function automatic logic [NC-1:0] exp_irq();
    logic [NC-1:0] v;
    for (int k = 0; k < NC; k++) v[k] = (m_time >= m_cmp[k]);
    return v;
  endfunction

  function automatic logic [31:0] model_read(input int a);
    if (a == 0) return m_time[31:0];
    if (a == 1) return m_sv ? m_sh : m_time[63:32];
    if (a == 2) return {16'h0, 8'(m_div), 7'h0, m_en};
    if (a == 3) return 32'(exp_irq());
    if (a >= 4 && a < 4 + 2*NC) return (a % 2 == 0) ? m_cmp[(a-4)/2][31:0] : m_cmp[(a-4)/2][63:32];
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_time = '0;
    for (int k = 0; k < NC; k++) m_cmp[k] = '1;
    m_en = 1'b1; m_div = 0; m_phase = 0;
    m_sv = 1'b0; m_sh = '0; m_rd = '0;
  endtask

  // One clock edge worth of timer behaviour, from the pre-edge state
  task automatic model_step();
    int a; bit tick; bit clr; logic [63:0] nt; logic n_en; int n_div;
    a = int'(addr);
    if (rd_en) m_rd = model_read(a);
    tick = m_en && (m_phase == m_div);
    nt = tick ? m_time + 64'd1 : m_time;
    clr = 0; n_en = m_en; n_div = m_div;
    if (wr_en) begin
      if (a == 0) begin nt = {m_time[63:32], mrg(m_time[31:0], wdata, strb)}; clr = 1; end
      else if (a == 1) begin nt = {mrg(m_time[63:32], wdata, strb), m_time[31:0]}; clr = 1; end
      else if (a == 2) begin
        if (strb[0]) n_en = wdata[0];
`ifdef MTIMER_PRESCALE_EN
        if (strb[1]) n_div = int'(wdata[15:8]);
`endif
        clr = 1;
      end else if (a >= 4 && a < 4 + 2*NC) begin
        if (a % 2 == 0) m_cmp[(a-4)/2][31:0]  = mrg(m_cmp[(a-4)/2][31:0], wdata, strb);
        else            m_cmp[(a-4)/2][63:32] = mrg(m_cmp[(a-4)/2][63:32], wdata, strb);
      end
    end
    if (rd_en || wr_en) begin
      if (rd_en && a == 0) begin m_sh = m_time[63:32]; m_sv = 1'b1; end
      else m_sv = 1'b0;
    end
    if (clr) m_phase = 0;
    else if (m_en) m_phase = tick ? 0 : m_phase + 1;
    m_time = nt; m_en = n_en; m_div = n_div;
  endtask

  task automatic step(input bit r, input bit w, input int a, input logic [31:0] d, input logic [3:0] s);
    rd_en = r; wr_en = w; addr = AW'(a); wdata = d; strb = s;
    @(posedge clk);
    model_step();
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 4'h0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("time", tdata, m_time);
        check("irq", 64'(irq), 64'(exp_irq()));
        check("rd_data", 64'(rdata), 64'(m_rd));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] target;
    logic [63:0] t0;
    int op;
    model_reset();
    @(negedge clk);
    check("rst_time", tdata, 64'h0);
    check("rst_irq", 64'(irq), 64'h0);
    check("rst_rd", 64'(rdata), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1;

    idle(5);
    check("time_after_5", tdata, 64'd5);

    step(1, 0, 4, 0, 0);  check("cmp0_lo_rst", 64'(rdata), 64'hFFFF_FFFF);
    step(1, 0, 2, 0, 0);  check("ctrl_rst", 64'(rdata), 64'h1);
    step(1, 0, 3, 0, 0);  check("pend_rst", 64'(rdata), 64'h0);

    step(0, 1, 4, 32'h0, 4'hF);
    step(0, 1, 5, 32'h0, 4'hF);
    check("irq_cmp0_zero", 64'(irq), 64'h1);

    target = m_time + 64'd10;
    step(0, 1, 4, target[31:0], 4'hF);
    check("irq0_cleared", 64'(irq[0]), 64'h0);
    for (int i = 0; i < 30 && tdata != target; i++) idle(1);
    check("irq0_at_target", {62'h0, tdata == target, irq[0]}, 64'h3);

    step(1, 1, 8, 32'h55, 4'hF);  check("rdwr_same_word", 64'(rdata), 64'hFFFF_FFFF);
    step(1, 0, 8, 0, 0);          check("cmp2_lo_written", 64'(rdata), 64'h55);
    step(0, 1, 13, 32'hDEAD_BEEF, 4'hF);
    step(1, 0, 13, 0, 0);         check("unmapped_rd", 64'(rdata), 64'h0);

    step(0, 1, 1, 32'h0, 4'hF);
    step(0, 1, 0, 32'hFFFF_FFFE, 4'hF);
    idle(1);
    step(1, 0, 0, 0, 0);  check("shadow_lo", 64'(rdata), 64'hFFFF_FFFF);
    step(1, 0, 1, 0, 0);  check("shadow_hi", 64'(rdata), 64'h0);
    step(1, 0, 0, 0, 0);  check("pair2_lo", 64'(rdata), 64'h1);
    step(1, 0, 1, 0, 0);  check("pair2_hi", 64'(rdata), 64'h1);

    step(0, 1, 6, 32'hFFFF_FFFF, 4'hF);
    step(0, 1, 7, 32'hFFFF_FFFF, 4'hF);
    step(0, 1, 1, 32'hFFFF_FFFF, 4'hF);
    step(0, 1, 0, 32'hFFFF_FFFF, 4'hF);
    check("irq1_at_max", 64'(irq[1]), 64'h1);
    idle(1);
    check("wrap_time", tdata, 64'h0);
    check("wrap_irq", 64'(irq), 64'h0);

    step(0, 1, 1, 32'h0, 4'hF);
    step(0, 1, 0, 32'h1234, 4'hF);
    step(0, 1, 0, 32'hAA, 4'h1);
    check("byte_strobe", tdata, 64'h12AA);
    step(0, 1, 3, 32'hFFFF_FFFF, 4'hF);
    step(1, 0, 3, 0, 0);  check("pending_ro", 64'(rdata), 64'h1);

`ifdef MTIMER_PRESCALE_EN
    step(0, 1, 2, 32'h0301, 4'hF);
    step(1, 0, 2, 0, 0);  check("ctrl_div3", 64'(rdata), 64'h301);
    t0 = tdata;
    idle(8);              check("div3_rate", tdata, t0 + 64'd2);
    step(0, 1, 2, 32'h0300, 4'hF);
    t0 = tdata;
    idle(5);              check("en0_freeze", tdata, t0);
`else
    step(0, 1, 2, 32'h0301, 4'hF);
    step(1, 0, 2, 0, 0);  check("ctrl_div_ro", 64'(rdata), 64'h1);
    t0 = tdata;
    idle(4);              check("nodiv_rate", tdata, t0 + 64'd4);
    step(0, 1, 2, 32'h0, 4'hF);
    t0 = tdata;
    idle(3);              check("en0_freeze", tdata, t0);
`endif
    step(0, 1, 2, 32'h1, 4'hF);

    for (int n = 0; n < 3000; n++) begin
      op = int'($urandom_range(0, 15));
      case (op)
        5, 6, 7: step(1, 0, int'($urandom_range(0, 15)), 0, 0);
        8: begin step(1, 0, 0, 0, 0); step(1, 0, 1, 0, 0); end
        9: begin
          int k;
          k = int'($urandom_range(0, NC-1));
          if ($urandom_range(0, 1) == 0)
            step(0, 1, 4 + 2*k, m_time[31:0] + $urandom_range(0, 30), 4'hF);
          else
            step(0, 1, 5 + 2*k, m_time[63:32], 4'hF);
        end
        10: step(0, 1, int'($urandom_range(0, 1)), $urandom, 4'($urandom));
        11: step(0, 1, 2, {16'h0, 8'($urandom_range(0, 3)), 7'h0, 1'($urandom_range(0, 7) != 0)},
                 4'($urandom));
        12: step(0, 1, int'($urandom_range(0, 15)), $urandom, 4'($urandom));
        13: step(1, 1, int'($urandom_range(0, 15)), $urandom, 4'($urandom));
        default: idle(1);
      endcase
    end

    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_time", tdata, 64'h0);
    check("async_rst_irq", 64'(irq), 64'h0);
    check("async_rst_rd", 64'(rdata), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    check("post_rst_time", tdata, 64'd3);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mtimer_n.md
# mtimer_n

Parametrised machine-timer block: a 64-bit free-running `mtime` counter with NUM_CMP independent 64-bit `mtimecmp` comparators, each driving one timer-interrupt line. It sits on the core's word-wide memory-mapped peripheral bus and is the multi-channel successor of the single-comparator `mtime` block. It adds an enable/prescale control register, a read-only pending register, and a coherent 64-bit read shadow. `time_rd_data` feeds the `time`/`timeh` CSRs directly.

## Interface
- NUM_CMP, 1, number of comparator/interrupt channels (1..8)
- PRESCALE_W, 8, width of the prescale divider field
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- rd_en  in  1  bus read strobe
- wr_en  in  1  bus write strobe
- addr  in  ADDR_W = $clog2(4+2*NUM_CMP)  word index
- wr_data  in  rv32::XLEN  write data
- wr_strobe  in  rv32::XLEN/8  byte-lane enables
- rd_data  out  rv32::XLEN  read data, registered
- time_rd_data  out  64  current mtime, combinational from register
- interrupt  out  NUM_CMP  per-channel timer interrupt

## Operation
- Word map: 0 mtime[31:0]; 1 mtime[63:32]; 2 ctrl; 3 pending (RO); 4+2k mtimecmp[k][31:0]; 5+2k mtimecmp[k][63:32]. Unmapped index: read 0, write ignored.
- ctrl: bit0 EN (reset 1); bits [8+PRESCALE_W-1:8] DIV (reset 0); other bits read 0.
- Tick: one tick every DIV+1 cycles while EN=1. Each tick increments mtime by 1. 2^64-1 wraps to 0.
- interrupt[k] = (mtime >= mtimecmp[k]), unsigned 64-bit, combinational from the registers. pending reads {interrupt} zero-extended. Writes to pending are ignored.
- Writes are byte-masked by wr_strobe. Unstrobed bytes keep their current (pre-increment) value.
- Write to word 0 or 1:
  - updates that half only;
  - suppresses the increment for the whole 64 bits in that cycle;
  - clears the prescale counter.
- Write to ctrl clears the prescale counter.
- Coherent read:
  - Reading word 0 returns mtime[31:0] and latches mtime[63:32] into hi_shadow.
  - Reading word 1 returns hi_shadow if the immediately preceding bus access was a read of word 0; otherwise it returns live mtime[63:32].
  - Any other access clears the shadow-valid flag.
- Simultaneous rd_en and wr_en to the same word: the read returns the pre-write value.

## Timing
- Reset values: mtime 0; every mtimecmp all-ones; EN=1, DIV=0; rd_data 0; prescale counter 0; shadow invalid; interrupt all 0.
- Register writes take effect at the sampling edge. interrupt reflects the new value after that edge, with no extra cycle.
- rd_data is valid the cycle after rd_en and holds its value until the next read.
- With DIV=0, EN=1, mtime advances every cycle starting from the first edge after reset release.
- Reset asserted mid-count: all state returns to reset values immediately (asynchronous).
- EN=0 freezes mtime and the prescale counter. Comparators stay live.

## Configuration
- MTIMER_PRESCALE_EN defined: the DIV field is implemented as described.
- MTIMER_PRESCALE_EN undefined: no prescale logic. DIV reads 0, writes to it are ignored, and a tick occurs every cycle while EN=1.

## Structure
- rv32 package: word-index constants (MTIMER_MTIME_LO, MTIMER_MTIME_HI, MTIMER_CTRL, MTIMER_PENDING, MTIMER_CMP_BASE) and ctrl field positions (MTIMER_CTRL_EN_BIT, MTIMER_CTRL_DIV_LSB).
- Sub-module mtimer_prescaler:
  - outputs a one-cycle tick;
  - inputs: EN, DIV, synchronous clear;
  - compiled only under MTIMER_PRESCALE_EN. Without the macro, tick = EN.
- Top level contains: address decode, byte-lane write merge, 64-bit counter, NUM_CMP comparator generate loop, read mux and shadow.

## Test plan
- Reset with NUM_CMP=2 -> interrupt=2'b00, mtimecmp reads 0xFFFF_FFFF, ctrl reads 0x1. mtime=5 five cycles after release.
- Write mtimecmp[0]={0,0} -> interrupt[0]=1 the next cycle while interrupt[1]=0. Then write mtimecmp[0] lo=mtime+10 -> interrupt[0]=0, and it reasserts exactly when time_rd_data equals that value.
- Write mtime hi=0, lo=0xFFFF_FFFE, let it run -> hi_shadow is coherent: read of lo 0xFFFF_FFFF followed by read of hi returns 0, not 1. Next lo/hi read pair gives 1/…
- Write mtime hi=lo=0xFFFF_FFFF, mtimecmp[1] hi=lo=0xFFFF_FFFF -> interrupt[1]=1. The following tick wraps mtime to 0 and interrupt[1]=0.
- With MTIMER_PRESCALE_EN, write ctrl DIV=3 -> mtime advances 1 per 4 cycles. EN=0 freezes mtime. Without the macro, DIV reads 0 and mtime advances every cycle.
- Write mtime lo with wr_strobe=4'b0001, data 0xAA, while mtime=0x1234 -> mtime lo=0x12AA, not incremented that cycle. Pending register write is ignored.
